// File: rtl/serial_pattern_scanner_pkg.sv
// Shared definitions for the serial 10101 pattern scanner: controller states,
// one-hot detector states and the pattern length.
package serial_pattern_scanner_pkg;

  localparam int unsigned PATTERN_LEN = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } ctrl_state_t;

  typedef enum logic [5:0] {
    DET_S0    = 6'b000001,
    DET_S1    = 6'b000010,
    DET_S2    = 6'b000100,
    DET_S3    = 6'b001000,
    DET_S4    = 6'b010000,
    DET_MATCH = 6'b100000
  } det_state_t;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/serial_pattern_scanner_det.sv
// Moore, non-overlapping detector for the serial pattern 1,0,1,0,1.
// State only advances when en is high; clr returns it to S0 synchronously.
module pattern_det_10101
  import serial_pattern_scanner_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic d_in,
  output logic y_out
);

  det_state_t state, state_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       state <= DET_S0;
    else if (clr)   state <= DET_S0;
    else if (en)    state <= state_nx;
  end

  always_comb begin
    state_nx = DET_S0;
    case (state)
      DET_S0:    state_nx = d_in ? DET_S1    : DET_S0;
      DET_S1:    state_nx = d_in ? DET_S1    : DET_S2;
      DET_S2:    state_nx = d_in ? DET_S3    : DET_S0;
      DET_S3:    state_nx = d_in ? DET_S1    : DET_S4;
      DET_S4:    state_nx = d_in ? DET_MATCH : DET_S0;
      DET_MATCH: state_nx = d_in ? DET_S1    : DET_S0;
      default:   state_nx = DET_S0;
    endcase
  end

  assign y_out = (state == DET_MATCH);

endmodule

// File: rtl/serial_pattern_scanner.sv
// Serialises parallel words into a 10101 detector and reports per-word and
// running (saturating) match counts through a valid/ready result handshake.
module serial_pattern_scanner
  import serial_pattern_scanner_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_count,
  output logic [15:0]      total_count,
  output logic             busy
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  ctrl_state_t      state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             step;
  logic             step_q;
  logic             ser_bit;
  logic             det_y;
  logic             accept;
  logic             hit;

  assign in_ready  = (state == ST_IDLE) && !clear;
  assign accept    = in_valid && in_ready;
  assign step      = (state == ST_SHIFT);
  assign ser_bit   = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  // The detector output is registered, so a hit is only trusted in the cycle
  // right after a real step; this stops a parked MATCH from being recounted.
  assign hit       = step_q && det_y;
  assign out_valid = (state == ST_REPORT);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_SHIFT;
      ST_SHIFT:  if (bit_cnt == '0) state_nx = ST_DRAIN;
      ST_DRAIN:  state_nx = ST_REPORT;
      ST_REPORT: if (out_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
    if (clear) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      step_q      <= 1'b0;
      out_count   <= '0;
      total_count <= '0;
    end else if (clear) begin
      step_q      <= 1'b0;
      out_count   <= '0;
      total_count <= '0;
    end else begin
      step_q <= step;
      if (accept) begin
        shreg   <= in_data;
        bit_cnt <= CNT_W'(WIDTH - 1);
      end else if (step) begin
        shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        if (bit_cnt != '0) bit_cnt <= bit_cnt - CNT_W'(1);
      end
      if (accept)   out_count <= '0;
      else if (hit) out_count <= sat_inc2(out_count);
      if (hit && (total_count != '1)) total_count <= total_count + 16'd1;
    end
  end

  pattern_det_10101 u_det (
    .clk   (clk),
    .rst   (rst),
    .en    (step),
    .clr   (clear),
    .d_in  (ser_bit),
    .y_out (det_y)
  );

endmodule

// File: tb/tb_serial_pattern_scanner.sv
// Self-checking bench: directed and random words against a bit-stream model
// of non-overlapping 10101 detection.
module tb_serial_pattern_scanner;

  localparam int W = 8;
  localparam logic [4:0] PAT = 5'b10101;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_count;
  logic [15:0]  total_count;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  // model: last five bits seen, bits since last match/clear, counts
  logic [4:0] m_hist;
  int         m_since;
  int         m_word;
  int         m_total;

  serial_pattern_scanner #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_count   (out_count),
    .total_count (total_count),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_hist  = '0;
    m_since = 0;
    m_word  = 0;
    m_total = 0;
  endtask

  task automatic model_word(input logic [W-1:0] d);
    m_word = 0;
    for (int i = W - 1; i >= 0; i--) begin
      m_hist = {m_hist[3:0], d[i]};
      if (m_since < 5) m_since++;
      if (m_since >= 5 && m_hist == PAT) begin
        m_word++;
        m_since = 0;
      end
    end
    if (m_word > 3) m_word = 3;
    m_total = (m_total + m_word > 65535) ? 65535 : m_total + m_word;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_count", out_count, 0);
    check("rst_total", total_count, 0);
    check("rst_busy", busy, 0);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
  endtask

  task automatic run_word(input logic [W-1:0] d, input int hold);
    int edges;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    model_word(d);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    edges = 0;
    while (out_valid !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check("latency", edges, W + 1);
    check("out_count", out_count, m_word);
    check("total_count", total_count, m_total);
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_data  = W'($urandom);
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_count", out_count, m_word);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("release_busy", busy, 0);
    check("release_valid", out_valid, 0);
  endtask

  task automatic watch_no_result(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0; in_data = '0;
    model_reset();

    do_reset();
    run_word(8'h15, 0);
    do_reset();
    run_word(8'hAA, 0);
    do_reset();
    run_word(8'h0A, 0);
    run_word(8'hA8, 0);
    run_word(8'h15, 5);

    // clear in the fourth SHIFT cycle of a word
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h15;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_busy", busy, 0);
    check("clear_total", total_count, 0);
    check("clear_out_count", out_count, 0);
    model_reset();
    watch_no_result("clear_no_result", 14);
    run_word(8'h15, 0);

    // clear wins over a simultaneous word
    @(negedge clk);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h15;
    #1 check("clear_in_ready", in_ready, 0);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    check("clear_no_accept", busy, 0);
    model_reset();

    for (int n = 0; n < 24; n++) run_word(W'($urandom), int'($urandom_range(0, 3)));

    // asynchronous reset in the middle of SHIFT
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_total", total_count, 0);
    check("arst_out_count", out_count, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    watch_no_result("arst_no_result", 14);
    run_word(8'h15, 1);
    run_word(8'h55, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
